// File: rtl/ahb_bus_matrix_decoder_param_if.sv
// Bus-side bundle for ahb_bus_matrix_decoder_param (address phase in, data-phase mux out).
// Optional macro AHB_DEC_ERR_LOG_EN adds err_clr / err_valid / err_addr.
interface ahb_bus_matrix_decoder_param_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_LSB  = 10,
  parameter int DATA_W    = 32,
  parameter int RUSER_W   = 32
);
  logic                                  HREADYS;
  logic                                  sel_dec;
  logic [31-ADDR_LSB:0]                  decode_addr_dec;
  logic [1:0]                            trans_dec;
  logic [NUM_PORTS-1:0]                  active_dec_i;
  logic [NUM_PORTS-1:0]                  readyout_dec;
  logic [NUM_PORTS-1:0][1:0]             resp_dec;
  logic [NUM_PORTS-1:0][DATA_W-1:0]      rdata_dec;
  logic [NUM_PORTS-1:0][RUSER_W-1:0]     ruser_dec;
  logic [NUM_PORTS-1:0]                  sel_port;
  logic                                  active_dec;
  logic                                  HREADYOUTS;
  logic [1:0]                            HRESPS;
  logic [DATA_W-1:0]                     HRDATAS;
  logic [RUSER_W-1:0]                    HRUSERS;
`ifdef AHB_DEC_ERR_LOG_EN
  logic                                  err_clr;
  logic                                  err_valid;
  logic [31-ADDR_LSB:0]                  err_addr;

  modport slave (
    input  HREADYS, sel_dec, decode_addr_dec, trans_dec, active_dec_i,
           readyout_dec, resp_dec, rdata_dec, ruser_dec, err_clr,
    output sel_port, active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS,
           err_valid, err_addr
  );
  modport master (
    output HREADYS, sel_dec, decode_addr_dec, trans_dec, active_dec_i,
           readyout_dec, resp_dec, rdata_dec, ruser_dec, err_clr,
    input  sel_port, active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS,
           err_valid, err_addr
  );
`else
  modport slave (
    input  HREADYS, sel_dec, decode_addr_dec, trans_dec, active_dec_i,
           readyout_dec, resp_dec, rdata_dec, ruser_dec,
    output sel_port, active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
  );
  modport master (
    output HREADYS, sel_dec, decode_addr_dec, trans_dec, active_dec_i,
           readyout_dec, resp_dec, rdata_dec, ruser_dec,
    input  sel_port, active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
  );
`endif
endinterface

// File: rtl/ahb_bus_matrix_decoder_param.sv
// AHB matrix input-stage decoder: address windows -> one-hot port select, default ERROR slave,
// registered data-phase port and response mux. Optional error log: AHB_DEC_ERR_LOG_EN.
module ahb_bus_matrix_decoder_param #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_LSB  = 10,
  parameter logic [NUM_PORTS-1:0][31-ADDR_LSB:0] BASE_ADDR  = {22'h100080, 22'h100040, 22'h100000},
  parameter logic [NUM_PORTS-1:0][31-ADDR_LSB:0] LIMIT_ADDR = {22'h1000bf, 22'h10007f, 22'h10003f},
  parameter int DATA_W    = 32,
  parameter int RUSER_W   = 32
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  ahb_bus_matrix_decoder_param_if.slave  bus
);
  localparam int DFT = NUM_PORTS;
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ERR1    = 2'b01;
  localparam logic [1:0] ST_ERR2    = 2'b10;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [NUM_PORTS:0] ONE = {{NUM_PORTS{1'b0}}, 1'b1};

  // one-hot over mapped ports plus the default slave in the top bit; all-zero dport means NONE
  logic [NUM_PORTS:0] w_dec, w_aport, r_dport;
  logic               w_hold, w_dft_req;
  logic [1:0]         r_state, w_state_nxt;
  logic               w_dft_ready;
  logic [1:0]         w_dft_resp;

  // Downward scan so the lowest matching window overwrites the others.
  always_comb begin
    w_dec      = '0;
    w_dec[DFT] = 1'b1;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      if ((bus.decode_addr_dec >= BASE_ADDR[i]) && (bus.decode_addr_dec <= LIMIT_ADDR[i])) begin
        w_dec    = '0;
        w_dec[i] = 1'b1;
      end
    end
  end

  assign w_hold         = (bus.trans_dec == 2'b00) && (|r_dport[NUM_PORTS-1:0]);
  assign w_aport        = w_hold ? r_dport : w_dec;
  assign bus.sel_port   = bus.sel_dec ? w_aport[NUM_PORTS-1:0] : '0;
  assign bus.active_dec = w_aport[DFT] | (|(w_aport[NUM_PORTS-1:0] & bus.active_dec_i));
  assign w_dft_req      = bus.sel_dec & w_aport[DFT] & bus.HREADYS & bus.trans_dec[1];

  always_ff @(posedge HCLK) begin
    if (HRESET)           r_dport <= '0;
    else if (bus.HREADYS) r_dport <= w_aport;
  end

  // Default slave: two-cycle ERROR response for every NONSEQ/SEQ it receives.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_nxt = w_dft_req ? ST_ERR1 : ST_IDLE;
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_ERR2: w_state_nxt = w_dft_req ? ST_ERR1 : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_dft_ready = (r_state != ST_ERR1);
  assign w_dft_resp  = (r_state == ST_IDLE) ? RESP_OKAY : RESP_ERROR;

  // Anything that is not exactly one-hot falls through to the NONE values.
  always_comb begin
    bus.HREADYOUTS = 1'b1;
    bus.HRESPS     = RESP_OKAY;
    bus.HRDATAS    = '0;
    bus.HRUSERS    = '0;
    if (r_dport == (ONE << DFT)) begin
      bus.HREADYOUTS = w_dft_ready;
      bus.HRESPS     = w_dft_resp;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_dport == (ONE << i)) begin
        bus.HREADYOUTS = bus.readyout_dec[i];
        bus.HRESPS     = bus.resp_dec[i];
        bus.HRDATAS    = bus.rdata_dec[i];
        bus.HRUSERS    = bus.ruser_dec[i];
      end
    end
  end

`ifdef AHB_DEC_ERR_LOG_EN
  logic                 r_err_valid;
  logic [31-ADDR_LSB:0] r_err_addr;

  // Only an IDLE->ERR1 entry can capture; clear beats a same-cycle capture.
  always_ff @(posedge HCLK) begin
    if (HRESET || bus.err_clr) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (!r_err_valid && (r_state == ST_IDLE) && w_dft_req) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= bus.decode_addr_dec;
    end
  end

  assign bus.err_valid = r_err_valid;
  assign bus.err_addr  = r_err_addr;
`endif
endmodule

// File: tb/tb_ahb_bus_matrix_decoder_param.sv
// Bench for ahb_bus_matrix_decoder_param: decode table, directed corner sequences,
// then random traffic against a transaction-level reference model.
module tb_ahb_bus_matrix_decoder_param;
  localparam int NP = 3, AL = 10, AW = 22, DW = 32, RW = 32;
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  ahb_bus_matrix_decoder_param_if #(.NUM_PORTS(NP), .ADDR_LSB(AL), .DATA_W(DW), .RUSER_W(RW)) bus ();
  ahb_bus_matrix_decoder_param #(.NUM_PORTS(NP), .ADDR_LSB(AL), .DATA_W(DW), .RUSER_W(RW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus));

  int nvec = 0, nmis = 0;
  int unsigned base [NP] = '{32'h100000, 32'h100040, 32'h100080};
  int unsigned limit[NP] = '{32'h10003f, 32'h10007f, 32'h1000bf};

  // Reference model: which slave owns the current data phase (-1 none, NP default slave),
  // and where the default slave is in its ERROR response (0 none, 1 wait cycle, 2 last cycle).
  int m_dp  = -1;
  int m_err = 0;
  bit m_ev  = 0;
  int unsigned m_ea = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int m_target();
    int unsigned a = 32'(bus.decode_addr_dec);
    if (bus.trans_dec == IDLE && m_dp >= 0 && m_dp < NP) return m_dp;
    for (int i = 0; i < NP; i++)
      if (a >= base[i] && a <= limit[i]) return i;
    return NP;
  endfunction

  task automatic m_clock();
    int t = m_target();
    bit req = bus.sel_dec && t == NP && bus.HREADYS && bus.trans_dec[1];
    if (HRESET) begin
      m_dp = -1; m_err = 0; m_ev = 0; m_ea = 0;
    end else begin
`ifdef AHB_DEC_ERR_LOG_EN
      if (bus.err_clr) begin m_ev = 0; m_ea = 0; end
      else if (!m_ev && m_err == 0 && req) begin m_ev = 1; m_ea = 32'(bus.decode_addr_dec); end
`endif
      m_err = (m_err == 1) ? 2 : (req ? 1 : 0);
      if (bus.HREADYS) m_dp = t;
    end
  endtask

  task automatic tick();
    m_clock();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_in(input logic s, input logic [AW-1:0] a, input logic [1:0] tr, input logic hr);
    bus.sel_dec = s; bus.decode_addr_dec = a; bus.trans_dec = tr; bus.HREADYS = hr;
  endtask

  task automatic check_model();
    int t = m_target();
    logic [NP-1:0] es = '0;
    logic ea, er; logic [1:0] ep; logic [DW-1:0] ed; logic [RW-1:0] eu;
    if (bus.sel_dec && t < NP) es[t] = 1'b1;
    ea = (t == NP) ? 1'b1 : bus.active_dec_i[t];
    if (m_dp < 0)        begin er = 1; ep = 0; ed = 0; eu = 0; end
    else if (m_dp == NP) begin er = (m_err != 1); ep = (m_err != 0) ? 2'b01 : 2'b00; ed = 0; eu = 0; end
    else begin
      er = bus.readyout_dec[m_dp]; ep = bus.resp_dec[m_dp];
      ed = bus.rdata_dec[m_dp];    eu = bus.ruser_dec[m_dp];
    end
    chk("rnd sel_port", 64'(bus.sel_port), 64'(es));
    chk("rnd active_dec", 64'(bus.active_dec), 64'(ea));
    chk("rnd HREADYOUTS", 64'(bus.HREADYOUTS), 64'(er));
    chk("rnd HRESPS", 64'(bus.HRESPS), 64'(ep));
    chk("rnd HRDATAS", 64'(bus.HRDATAS), 64'(ed));
    chk("rnd HRUSERS", 64'(bus.HRUSERS), 64'(eu));
`ifdef AHB_DEC_ERR_LOG_EN
    chk("rnd err_valid", 64'(bus.err_valid), 64'(m_ev));
    chk("rnd err_addr", 64'(bus.err_addr), 64'(m_ea));
`endif
  endtask

  typedef struct {
    logic          sel;
    logic [AW-1:0] addr;
    logic [NP-1:0] act;
    logic [NP-1:0] exp_sel;
    logic          exp_act;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 22'h100000, 3'b111, 3'b001, 1'b1};
    tbl[1]  = '{1'b1, 22'h10003f, 3'b111, 3'b001, 1'b1};
    tbl[2]  = '{1'b1, 22'h100040, 3'b111, 3'b010, 1'b1};
    tbl[3]  = '{1'b1, 22'h10007f, 3'b101, 3'b010, 1'b0};
    tbl[4]  = '{1'b1, 22'h100080, 3'b011, 3'b100, 1'b0};
    tbl[5]  = '{1'b1, 22'h1000bf, 3'b111, 3'b100, 1'b1};
    tbl[6]  = '{1'b1, 22'h0fffff, 3'b000, 3'b000, 1'b1};
    tbl[7]  = '{1'b1, 22'h1000c0, 3'b000, 3'b000, 1'b1};
    tbl[8]  = '{1'b0, 22'h100000, 3'b111, 3'b000, 1'b1};
    tbl[9]  = '{1'b0, 22'h140000, 3'b000, 3'b000, 1'b1};
    tbl[10] = '{1'b1, 22'h000000, 3'b111, 3'b000, 1'b1};
    tbl[11] = '{1'b1, 22'h100041, 3'b010, 3'b010, 1'b1};

    HRESET = 1'b1;
    set_in(0, '0, IDLE, 1);
    bus.active_dec_i = '1;
    bus.readyout_dec = '1;
    bus.resp_dec     = '0;
    bus.rdata_dec    = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    bus.ruser_dec    = {32'h3, 32'h2, 32'h1};
`ifdef AHB_DEC_ERR_LOG_EN
    bus.err_clr = 1'b0;
`endif
    @(posedge HCLK); #1;
    tick(); tick();
    HRESET = 1'b0;
    #1;
    chk("reset sel_port", 64'(bus.sel_port), 0);
    chk("reset HREADYOUTS", 64'(bus.HREADYOUTS), 1);
    chk("reset HRESPS", 64'(bus.HRESPS), 0);
    chk("reset HRDATAS", 64'(bus.HRDATAS), 0);

    // Decode table; HREADYS low keeps the data phase at NONE throughout.
    for (int v = 0; v < 12; v++) begin
      set_in(tbl[v].sel, tbl[v].addr, NONSEQ, 0);
      bus.active_dec_i = tbl[v].act;
      #1;
      chk($sformatf("tbl%0d sel_port", v), 64'(bus.sel_port), 64'(tbl[v].exp_sel));
      chk($sformatf("tbl%0d active_dec", v), 64'(bus.active_dec), 64'(tbl[v].exp_act));
      chk($sformatf("tbl%0d HREADYOUTS", v), 64'(bus.HREADYOUTS), 1);
      tick();
    end
    bus.active_dec_i = '1;

    // Port 1 read: select in address phase, slice 1 in data phase.
    set_in(1, 22'h100040, NONSEQ, 1); #1;
    chk("p1 sel_port", 64'(bus.sel_port), 64'h2);
    tick();
    set_in(0, '0, IDLE, 1); #1;
    chk("p1 HRDATAS", 64'(bus.HRDATAS), 64'hBBBB_0001);
    chk("p1 HRUSERS", 64'(bus.HRUSERS), 64'h2);
    tick();

    // Single unmapped NONSEQ: wait+ERROR, ready+ERROR, then OKAY.
    set_in(1, 22'h140000, NONSEQ, 1); #1;
    chk("dft sel_port", 64'(bus.sel_port), 0);
    chk("dft active_dec", 64'(bus.active_dec), 1);
    tick();
    set_in(0, '0, IDLE, 0); #1;
    chk("err1 HREADYOUTS", 64'(bus.HREADYOUTS), 0);
    chk("err1 HRESPS", 64'(bus.HRESPS), 1);
    tick();
    set_in(0, '0, IDLE, 1); #1;
    chk("err2 HREADYOUTS", 64'(bus.HREADYOUTS), 1);
    chk("err2 HRESPS", 64'(bus.HRESPS), 1);
    tick(); #1;
    chk("post-err HREADYOUTS", 64'(bus.HREADYOUTS), 1);
    chk("post-err HRESPS", 64'(bus.HRESPS), 0);

    // IDLE hold on port 0 with an address inside port 2's window.
    set_in(1, 22'h100000, NONSEQ, 1);
    tick();
    set_in(1, 22'h100080, IDLE, 1); #1;
    chk("idle hold sel_port", 64'(bus.sel_port), 64'h1);
    tick();

    // Back-to-back unmapped transfers.
    set_in(1, 22'h140000, NONSEQ, 1);
    tick();
    set_in(1, 22'h140000, NONSEQ, 0); #1;
    chk("b2b err1a ready", 64'(bus.HREADYOUTS), 0);
    chk("b2b err1a resp", 64'(bus.HRESPS), 1);
    tick();
    set_in(1, 22'h150000, NONSEQ, 1); #1;
    chk("b2b err2a ready", 64'(bus.HREADYOUTS), 1);
    chk("b2b err2a resp", 64'(bus.HRESPS), 1);
    tick();
    set_in(1, 22'h150000, NONSEQ, 0); #1;
    chk("b2b err1b ready", 64'(bus.HREADYOUTS), 0);
    chk("b2b err1b resp", 64'(bus.HRESPS), 1);
    tick();
    set_in(0, '0, IDLE, 1); #1;
    chk("b2b err2b ready", 64'(bus.HREADYOUTS), 1);
    chk("b2b err2b resp", 64'(bus.HRESPS), 1);
    tick(); #1;
    chk("b2b idle resp", 64'(bus.HRESPS), 0);

    // HREADYS low holds the data-phase port.
    set_in(1, 22'h100040, NONSEQ, 1);
    tick();
    set_in(1, 22'h100080, NONSEQ, 0);
    tick(); #1;
    chk("hold HRDATAS", 64'(bus.HRDATAS), 64'hBBBB_0001);
    bus.HREADYS = 1'b1;
    tick();
    set_in(0, '0, IDLE, 1); #1;
    chk("advance HRDATAS", 64'(bus.HRDATAS), 64'hCCCC_0002);
    tick();

    // Reset during ERR1 leaves no ERROR behind.
    set_in(1, 22'h140000, NONSEQ, 1);
    tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    set_in(0, '0, IDLE, 1); #1;
    chk("rst-mid HREADYOUTS", 64'(bus.HREADYOUTS), 1);
    chk("rst-mid HRESPS", 64'(bus.HRESPS), 0);

`ifdef AHB_DEC_ERR_LOG_EN
    set_in(1, 22'h140001, NONSEQ, 1);
    tick();
    set_in(1, 22'h140001, NONSEQ, 0);
    tick();
    set_in(1, 22'h180000, NONSEQ, 1);
    tick();
    set_in(1, 22'h180000, NONSEQ, 0);
    tick();
    set_in(0, '0, IDLE, 1);
    tick();
    chk("log err_valid", 64'(bus.err_valid), 1);
    chk("log err_addr", 64'(bus.err_addr), 64'h140001);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("log clr err_valid", 64'(bus.err_valid), 0);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int unsigned a;
      int k = $urandom_range(0, NP-1);
      case ($urandom_range(0, 4))
        0, 1: a = base[k] + $urandom_range(0, limit[k] - base[k]);
        2: case ($urandom_range(0, 3))
             0: a = base[k];
             1: a = limit[k];
             2: a = base[k] - 1;
             default: a = limit[k] + 1;
           endcase
        3: a = 32'h140000 + $urandom_range(0, 255);
        default: a = $urandom;
      endcase
      HRESET = ($urandom_range(0, 199) == 0);
      set_in(($urandom_range(0, 7) != 0), a[AW-1:0], 2'($urandom_range(0, 3)),
             ($urandom_range(0, 3) != 0));
      bus.active_dec_i = 3'($urandom);
      bus.readyout_dec = 3'($urandom);
      bus.resp_dec     = 6'($urandom);
      bus.rdata_dec    = {$urandom, $urandom, $urandom};
      bus.ruser_dec    = {$urandom, $urandom, $urandom};
`ifdef AHB_DEC_ERR_LOG_EN
      bus.err_clr = ($urandom_range(0, 49) == 0);
`endif
      #1;
      check_model();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
